spi_slave_word: RTL and testbench
=================================

Name: spi_slave_word

Overview:
- Parametrised SPI slave: configurable word width, SPI mode (CPOL/CPHA), bit order, full-duplex word stream per chip-select frame.
- Sits between the external MCU SPI pins and the register/command layer. Presents received words as single-cycle pulses and accepts TX words through a one-entry ready/valid holding buffer.
- Adds over the previous slave: input synchronisation, all four SPI modes, underrun fill word, frame-end and abort reporting.

Parameters:
- WIDTH, 8: bits per SPI word (2..32).
- CPOL, 0: SCK idle level.
- CPHA, 0: 0 = sample on leading edge, shift on trailing; 1 = shift on leading, sample on trailing.
- MSB_FIRST, 1: 1 = MSB shifted first, 0 = LSB first.
- FILL, 0: word (WIDTH bits) shifted out when no TX word is available.

Ports:
- clk  in  1  system clock; SCK frequency ≤ clk/8.
- rst_n  in  1  asynchronous active-low reset.
- si  in  1  MOSI pin.
- n_cs  in  1  chip select pin, active low.
- sck  in  1  SPI clock pin.
- so  out  1  MISO data.
- so_oe  out  1  MISO output enable = ~n_cs (combinational from pin, so release is immediate).
- start  out  1  one-cycle pulse on synchronised n_cs falling edge.
- frame_end  out  1  one-cycle pulse on synchronised n_cs rising edge.
- abort  out  1  pulses with frame_end when bit count ≠ 0 (partial word discarded).
- data_rx  out  WIDTH  last complete received word, held until next.
- valid_rx  out  1  one-cycle pulse, data_rx updated same cycle; no backpressure.
- data_tx  in  WIDTH  next TX word.
- valid_tx  in  1  TX word offered.
- ready_tx  out  1  holding buffer empty.
- tx_underrun  out  1  one-cycle pulse when FILL is loaded instead of a buffered word.

Behaviour:
- Reset (async, rst_n=0): shift register 0, bit count 0, buffer empty, ready_tx=1, data_rx=0, all pulses 0, sync stages to idle (n_cs=1, sck=CPOL).
- Edges are detected on synchronised sck/n_cs. Leading edge = sck leaves CPOL; trailing edge = sck returns to CPOL. Edges are ignored while synchronised n_cs=1.
- Sample edge: latch si into the receive path and increment count. At count==WIDTH-1: data_rx = assembled word, valid_rx=1, count wraps to 0.
- Shift edge: advance the shift register; so = shift[WIDTH-1] if MSB_FIRST, else shift[0].
- Word load:
  - CPHA=0: at start (the first bit must be valid before the first edge), then on every trailing edge following a word completion.
  - CPHA=1: on the leading edge when count==0.
  - A load consumes the buffer (ready_tx=1 next cycle). If the buffer is empty, FILL is loaded and tx_underrun pulses.
- TX handshake: valid_tx && ready_tx stores data_tx and sets ready_tx=0 next cycle.
  - If a load and an accept coincide while the buffer is empty, the load takes FILL and the new word stays buffered.
  - If a load consumes a full buffer in the same cycle an accept is offered, the accept is refused because ready_tx was 0.
- n_cs rising mid-word: count reset to 0, partial RX discarded (no valid_rx), abort + frame_end pulse. The buffer is kept.
- n_cs falling and rising edges are never reported in the same cycle. A rising edge followed by an immediate falling edge produces frame_end, then start on a later cycle.
- Latency: pin edge to internal action = sync depth + 1 clk (3 with SPI_SYNC_EN, 2 without).

Optional Feature:
- SPI_SYNC_EN defined: 2-flop synchronisers on si, sck, n_cs plus an edge-detect register.
- SPI_SYNC_EN undefined: single register stage only (for use when the pins are already synchronous to clk).
- Functional behaviour is identical in both cases; only latency differs.

Decomposition:
- Package spi_pkg: mode constants SPI_MODE0..3 (CPOL/CPHA pairs), default FILL, edge-type enum (NONE, LEAD, TRAIL).
- Sub-module spi_pin_sync: synchroniser plus edge detector producing lead/trail/cs_fall/cs_rise pulses. Its depth is selected by SPI_SYNC_EN.

Test Plan:
- Mode 0, WIDTH=8, preload 0xA5, master sends 0x3C → so shifts 1010_0101, valid_rx with data_rx=0x3C, ready_tx rises after load.
- All four modes, WIDTH=16, 3-word frame TX 0x1234/0x5678/0x9ABC → master reads same words, RX loopback matches, no underrun.
- No TX word offered, FILL=0xFF → master reads 0xFF, tx_underrun pulses once per word.
- n_cs released after 5 bits → abort+frame_end pulse, no valid_rx; next frame starts at bit 0 correctly.
- rst_n asserted mid-word → all outputs at reset values immediately; the first frame after release is correct.
- MSB_FIRST=0, TX 0x01 → first bit on so is 1.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the word-oriented SPI slave.
//   SPI_MODE0..3      : {CPOL, CPHA} pairs for the four standard SPI modes
//   SPI_FILL_DEFAULT  : word shifted out when no TX word is buffered
//   spi_edge_e        : classification of a synchronised SCK transition
package spi_pkg;

    // {CPOL, CPHA}
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    localparam logic [31:0] SPI_FILL_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        EDGE_NONE  = 2'b00,
        EDGE_LEAD  = 2'b01,
        EDGE_TRAIL = 2'b10
    } spi_edge_e;

endpackage

// File: rtl/spi_pin_sync.sv
// Pin conditioning for the SPI slave: brings si/sck/n_cs into the clk domain
// and classifies transitions.
//   Macro SPI_SYNC_EN : defined   -> 2-flop synchronisers on every pin
//                       undefined -> single register stage (pins already
//                                    synchronous to clk)
// Ports:
//   clk, rst_n        : system clock, async active-low reset
//   si, sck, n_cs     : raw SPI pins
//   si_sync           : si delayed by the same depth as sck
//   sck_edge          : LEAD/TRAIL pulse, NONE while chip select is inactive
//   cs_fall, cs_rise  : one-cycle pulses on synchronised n_cs edges
module spi_pin_sync
    import spi_pkg::*;
#(
    parameter logic IDLE_SCK = 1'b0
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      si,
    input  logic      sck,
    input  logic      n_cs,
    output logic      si_sync,
    output spi_edge_e sck_edge,
    output logic      cs_fall,
    output logic      cs_rise
);

    logic sck_s;
    logic cs_s;
    logic sck_prev_r;
    logic cs_prev_r;

`ifdef SPI_SYNC_EN
    logic [1:0] si_pipe_r;
    logic [1:0] sck_pipe_r;
    logic [1:0] cs_pipe_r;

    // Two-flop synchronisers; reset to the idle pin levels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            si_pipe_r  <= 2'b00;
            sck_pipe_r <= {2{IDLE_SCK}};
            cs_pipe_r  <= 2'b11;
        end else begin
            si_pipe_r  <= {si_pipe_r[0], si};
            sck_pipe_r <= {sck_pipe_r[0], sck};
            cs_pipe_r  <= {cs_pipe_r[0], n_cs};
        end
    end

    assign si_sync = si_pipe_r[1];
    assign sck_s   = sck_pipe_r[1];
    assign cs_s    = cs_pipe_r[1];
`else
    logic si_pipe_r;
    logic sck_pipe_r;
    logic cs_pipe_r;

    // Single capture stage; reset to the idle pin levels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            si_pipe_r  <= 1'b0;
            sck_pipe_r <= IDLE_SCK;
            cs_pipe_r  <= 1'b1;
        end else begin
            si_pipe_r  <= si;
            sck_pipe_r <= sck;
            cs_pipe_r  <= n_cs;
        end
    end

    assign si_sync = si_pipe_r;
    assign sck_s   = sck_pipe_r;
    assign cs_s    = cs_pipe_r;
`endif

    // Previous synchronised levels for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_prev_r <= IDLE_SCK;
            cs_prev_r  <= 1'b1;
        end else begin
            sck_prev_r <= sck_s;
            cs_prev_r  <= cs_s;
        end
    end

    // Classify the SCK transition; leaving the idle level is the leading edge
    always_comb begin
        sck_edge = EDGE_NONE;
        if (cs_s || (sck_s == sck_prev_r)) begin
            sck_edge = EDGE_NONE;
        end else if (sck_s != IDLE_SCK) begin
            sck_edge = EDGE_LEAD;
        end else begin
            sck_edge = EDGE_TRAIL;
        end
    end

    assign cs_fall = cs_prev_r & ~cs_s;
    assign cs_rise = ~cs_prev_r & cs_s;

endmodule

// File: rtl/spi_slave_word.sv
// Word-oriented full-duplex SPI slave, any CPOL/CPHA, either bit order.
//   Macro SPI_SYNC_EN : selects 2-flop pin synchronisers (see spi_pin_sync).
// Ports:
//   clk, rst_n            : system clock, async active-low reset
//   si, n_cs, sck         : MOSI, chip select (active low), SPI clock pins
//   so, so_oe             : MISO data and output enable (~n_cs, unregistered)
//   start, frame_end      : pulses on chip-select assertion / release
//   abort                 : with frame_end when a partial word was discarded
//   data_rx, valid_rx     : received word and its one-cycle strobe
//   data_tx, valid_tx,    : one-entry TX holding buffer, ready/valid
//   ready_tx
//   tx_underrun           : FILL was loaded because the buffer was empty
module spi_slave_word
    import spi_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               CPOL      = 0,
    parameter int               CPHA      = 0,
    parameter int               MSB_FIRST = 1,
    parameter logic [WIDTH-1:0] FILL      = WIDTH'(SPI_FILL_DEFAULT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             si,
    input  logic             n_cs,
    input  logic             sck,
    output logic             so,
    output logic             so_oe,
    output logic             start,
    output logic             frame_end,
    output logic             abort,
    output logic [WIDTH-1:0] data_rx,
    output logic             valid_rx,
    input  logic [WIDTH-1:0] data_tx,
    input  logic             valid_tx,
    output logic             ready_tx,
    output logic             tx_underrun
);

    localparam int             CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic           IDLE_SCK = (CPOL != 0) ? 1'b1 : 1'b0;
    localparam int             SO_IDX   = (MSB_FIRST != 0) ? WIDTH - 1 : 0;

    logic             si_s;
    spi_edge_e        sck_edge_s;
    logic             cs_fall_s;
    logic             cs_rise_s;

    logic [WIDTH-1:0] shift_r;
    logic [WIDTH-1:0] rx_r;
    logic [WIDTH-1:0] buf_r;
    logic             buf_full_r;
    logic [CNT_W-1:0] cnt_r;
    logic             load_pend_r;
    logic [WIDTH-1:0] data_rx_r;
    logic             valid_rx_r;
    logic             start_r;
    logic             frame_end_r;
    logic             abort_r;
    logic             underrun_r;

    logic             sample_s;
    logic             shift_s;
    logic             load_s;
    logic             accept_s;
    logic [WIDTH-1:0] rx_next_s;
    logic [WIDTH-1:0] shift_next_s;
    logic [WIDTH-1:0] load_word_s;

    spi_pin_sync #(
        .IDLE_SCK (IDLE_SCK)
    ) u_pin_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .si       (si),
        .sck      (sck),
        .n_cs     (n_cs),
        .si_sync  (si_s),
        .sck_edge (sck_edge_s),
        .cs_fall  (cs_fall_s),
        .cs_rise  (cs_rise_s)
    );

    // Map SCK edges onto sample/shift/load actions for the selected phase
    always_comb begin
        sample_s = 1'b0;
        shift_s  = 1'b0;
        load_s   = 1'b0;
        if (CPHA == 0) begin
            // First bit must be on the wire before the first edge, so the
            // word is loaded at frame start and after every completed word.
            sample_s = (sck_edge_s == EDGE_LEAD);
            shift_s  = (sck_edge_s == EDGE_TRAIL);
            load_s   = (cs_fall_s | ((sck_edge_s == EDGE_TRAIL) & load_pend_r)) & ~cs_rise_s;
        end else begin
            sample_s = (sck_edge_s == EDGE_TRAIL);
            shift_s  = (sck_edge_s == EDGE_LEAD);
            load_s   = (sck_edge_s == EDGE_LEAD) & (cnt_r == CNT_W'(0)) & ~cs_rise_s;
        end
    end

    // Next values of the receive and transmit shift paths
    always_comb begin
        rx_next_s    = rx_r;
        shift_next_s = shift_r;
        if (MSB_FIRST != 0) begin
            rx_next_s    = {rx_r[WIDTH-2:0], si_s};
            shift_next_s = {shift_r[WIDTH-2:0], 1'b0};
        end else begin
            rx_next_s    = {si_s, rx_r[WIDTH-1:1]};
            shift_next_s = {1'b0, shift_r[WIDTH-1:1]};
        end
    end

    // Word to load: buffered word if present, otherwise the fill pattern
    always_comb begin
        load_word_s = FILL;
        if (buf_full_r) begin
            load_word_s = buf_r;
        end else begin
            load_word_s = FILL;
        end
    end

    assign accept_s = valid_tx & ~buf_full_r;

    // Frame control, bit counting, shift paths and TX holding buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r     <= {WIDTH{1'b0}};
            rx_r        <= {WIDTH{1'b0}};
            buf_r       <= {WIDTH{1'b0}};
            buf_full_r  <= 1'b0;
            cnt_r       <= CNT_W'(0);
            load_pend_r <= 1'b0;
            data_rx_r   <= {WIDTH{1'b0}};
            valid_rx_r  <= 1'b0;
            start_r     <= 1'b0;
            frame_end_r <= 1'b0;
            abort_r     <= 1'b0;
            underrun_r  <= 1'b0;
        end else begin
            start_r     <= 1'b0;
            frame_end_r <= 1'b0;
            abort_r     <= 1'b0;
            valid_rx_r  <= 1'b0;
            underrun_r  <= 1'b0;
            if (cs_rise_s) begin
                // Partial word is dropped; the TX buffer survives the frame end
                frame_end_r <= 1'b1;
                abort_r     <= (cnt_r != CNT_W'(0));
                cnt_r       <= CNT_W'(0);
                load_pend_r <= 1'b0;
            end else begin
                if (cs_fall_s) begin
                    start_r     <= 1'b1;
                    cnt_r       <= CNT_W'(0);
                    load_pend_r <= 1'b0;
                end else begin
                    start_r     <= 1'b0;
                end
                if (sample_s) begin
                    rx_r <= rx_next_s;
                    if (cnt_r == LAST_CNT) begin
                        cnt_r       <= CNT_W'(0);
                        data_rx_r   <= rx_next_s;
                        valid_rx_r  <= 1'b1;
                        load_pend_r <= (CPHA == 0);
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end else begin
                    rx_r <= rx_r;
                end
                if (load_s) begin
                    shift_r     <= load_word_s;
                    load_pend_r <= 1'b0;
                    underrun_r  <= ~buf_full_r;
                end else if (shift_s) begin
                    shift_r <= shift_next_s;
                end else begin
                    shift_r <= shift_r;
                end
            end
            // A load from a full buffer wins; ready_tx was low so no accept
            if (load_s && buf_full_r) begin
                buf_full_r <= 1'b0;
            end else if (accept_s) begin
                buf_r      <= data_tx;
                buf_full_r <= 1'b1;
            end else begin
                buf_full_r <= buf_full_r;
            end
        end
    end

    assign so          = shift_r[SO_IDX];
    assign so_oe       = ~n_cs;
    assign start       = start_r;
    assign frame_end   = frame_end_r;
    assign abort       = abort_r;
    assign data_rx     = data_rx_r;
    assign valid_rx    = valid_rx_r;
    assign ready_tx    = ~buf_full_r;
    assign tx_underrun = underrun_r;

endmodule

// File: tb/tb_spi_slave_word.sv
// Directed bench for spi_slave_word. Six instances:
//   0: WIDTH=8, mode 0, MSB first, FILL=0xFF
//   1..4: WIDTH=16, modes 0..3, MSB first, FILL=0
//   5: WIDTH=8, mode 0, LSB first, FILL=0
module tb_spi_slave_word;
    import spi_pkg::*;

    localparam int N    = 6;
    localparam int HALF = 8;   // SCK half period in clk cycles

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         si    = 1'b0;
    logic [N-1:0] n_cs  = 6'b111111;
    logic [N-1:0] sck   = 6'b011000;   // instances 3,4 idle high
    logic [N-1:0] so, so_oe, start, frame_end, abort, valid_rx, ready_tx, tx_underrun;
    logic [N-1:0] valid_tx = 6'b000000;
    logic [15:0]  data_tx [N];
    logic [15:0]  data_rx_a [N];
    logic [7:0]   rx8_0, rx8_5;
    logic [15:0]  rx16 [1:4];

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    spi_slave_word #(.WIDTH(8), .CPOL(int'(SPI_MODE0[1])), .CPHA(int'(SPI_MODE0[0])),
                     .MSB_FIRST(1), .FILL(8'hFF)) u_w8 (
        .clk(clk), .rst_n(rst_n), .si(si), .n_cs(n_cs[0]), .sck(sck[0]),
        .so(so[0]), .so_oe(so_oe[0]), .start(start[0]), .frame_end(frame_end[0]),
        .abort(abort[0]), .data_rx(rx8_0), .valid_rx(valid_rx[0]),
        .data_tx(data_tx[0][7:0]), .valid_tx(valid_tx[0]), .ready_tx(ready_tx[0]),
        .tx_underrun(tx_underrun[0]));

    for (genvar g = 1; g <= 4; g++) begin : g_mode
        localparam logic [1:0] MODE = 2'(g - 1);
        spi_slave_word #(.WIDTH(16), .CPOL(int'(MODE[1])), .CPHA(int'(MODE[0])),
                         .MSB_FIRST(1), .FILL(16'h0000)) u_w16 (
            .clk(clk), .rst_n(rst_n), .si(si), .n_cs(n_cs[g]), .sck(sck[g]),
            .so(so[g]), .so_oe(so_oe[g]), .start(start[g]), .frame_end(frame_end[g]),
            .abort(abort[g]), .data_rx(rx16[g]), .valid_rx(valid_rx[g]),
            .data_tx(data_tx[g]), .valid_tx(valid_tx[g]), .ready_tx(ready_tx[g]),
            .tx_underrun(tx_underrun[g]));
    end

    spi_slave_word #(.WIDTH(8), .CPOL(0), .CPHA(0), .MSB_FIRST(0), .FILL(8'h00)) u_lsb (
        .clk(clk), .rst_n(rst_n), .si(si), .n_cs(n_cs[5]), .sck(sck[5]),
        .so(so[5]), .so_oe(so_oe[5]), .start(start[5]), .frame_end(frame_end[5]),
        .abort(abort[5]), .data_rx(rx8_5), .valid_rx(valid_rx[5]),
        .data_tx(data_tx[5][7:0]), .valid_tx(valid_tx[5]), .ready_tx(ready_tx[5]),
        .tx_underrun(tx_underrun[5]));

    always_comb begin
        data_rx_a[0] = {8'h00, rx8_0};
        data_rx_a[1] = rx16[1];
        data_rx_a[2] = rx16[2];
        data_rx_a[3] = rx16[3];
        data_rx_a[4] = rx16[4];
        data_rx_a[5] = {8'h00, rx8_5};
    end

    // Pulse counters and received-word history
    int          n_vrx [N];
    int          n_und [N];
    int          n_abt [N];
    int          n_fe  [N];
    int          n_st  [N];
    logic [15:0] rx_hist [N][8];

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (valid_rx[i]) begin
                rx_hist[i][n_vrx[i] % 8] <= data_rx_a[i];
                n_vrx[i] <= n_vrx[i] + 1;
            end
            if (tx_underrun[i]) n_und[i] <= n_und[i] + 1;
            if (abort[i])       n_abt[i] <= n_abt[i] + 1;
            if (frame_end[i])   n_fe[i]  <= n_fe[i] + 1;
            if (start[i])       n_st[i]  <= n_st[i] + 1;
        end
    end

    // TX feeder: offers queue heads, pops once the handshake has happened
    logic [15:0]  txq [N][$];
    logic [N-1:0] pend = 6'b000000;

    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (pend[i]) void'(txq[i].pop_front());
                if (txq[i].size() > 0) begin
                    valid_tx[i] = 1'b1;
                    data_tx[i]  = txq[i][0];
                end else begin
                    valid_tx[i] = 1'b0;
                end
                pend[i] = valid_tx[i] & ready_tx[i] & rst_n;
            end
        end
    end

    // SPI master model
    logic [15:0] m_tx [4];
    logic [15:0] m_rx [4];
    logic        first_bit;

    task automatic spi_frame(input int i, input int w, input int cpha, input bit msb,
                             input int nbits, input bit release_cs);
        logic idle;
        int   k, j, pos;
        idle = sck[i];
        for (int q = 0; q < 4; q++) m_rx[q] = 16'h0000;
        n_cs[i] = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int b = 0; b < nbits; b++) begin
            k   = b / w;
            j   = b % w;
            pos = msb ? (w - 1 - j) : j;
            if (cpha == 0) begin
                si = m_tx[k][pos];
                repeat (HALF) @(negedge clk);
                m_rx[k][pos] = so[i];
                sck[i] = ~idle;
                repeat (HALF) @(negedge clk);
                sck[i] = idle;
            end else begin
                sck[i] = ~idle;
                si = m_tx[k][pos];
                repeat (HALF) @(negedge clk);
                m_rx[k][pos] = so[i];
                sck[i] = idle;
                repeat (HALF) @(negedge clk);
            end
            if (b == 0) first_bit = m_rx[k][pos];
        end
        repeat (HALF) @(negedge clk);
        if (release_cs) begin
            n_cs[i] = 1'b1;
            repeat (2 * HALF) @(negedge clk);
        end
    endtask

    task automatic wait_loaded(input int i);
        int t = 0;
        while (ready_tx[i] !== 1'b0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        total++;
        if (ready_tx[i] !== 1'b0) $display("FAIL tx_accept inst %0d ready_tx=%b expected 0", i, ready_tx[i]);
        else passed++;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if (ready_tx !== 6'b111111) $display("FAIL reset_ready got %b expected 111111", ready_tx);
        else passed++;
        total++;
        if ({valid_rx, start, frame_end, abort, tx_underrun} !== 30'h0)
            $display("FAIL reset_pulses got %h expected 0", {valid_rx, start, frame_end, abort, tx_underrun});
        else passed++;
        total++;
        if (data_rx_a[0] !== 16'h0000 || data_rx_a[2] !== 16'h0000)
            $display("FAIL reset_data_rx got %h/%h expected 0", data_rx_a[0], data_rx_a[2]);
        else passed++;
        total++;
        if (so !== 6'b000000 || so_oe !== 6'b000000)
            $display("FAIL reset_so so=%b so_oe=%b expected 0/0", so, so_oe);
        else passed++;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_preload();
        int v0, u0, s0, f0, a0;
        txq[0].push_back(16'h00A5);
        wait_loaded(0);
        v0 = n_vrx[0]; u0 = n_und[0]; s0 = n_st[0]; f0 = n_fe[0]; a0 = n_abt[0];
        m_tx[0] = 16'h003C;
        spi_frame(0, 8, 0, 1'b1, 8, 1'b1);
        total++;
        if (m_rx[0][7:0] !== 8'hA5) $display("FAIL preload_miso got %h expected a5", m_rx[0][7:0]);
        else passed++;
        total++;
        if (data_rx_a[0] !== 16'h003C || n_vrx[0] - v0 !== 1)
            $display("FAIL preload_rx got %h/%0d expected 003c/1", data_rx_a[0], n_vrx[0] - v0);
        else passed++;
        total++;
        if (ready_tx[0] !== 1'b1) $display("FAIL preload_ready got %b expected 1", ready_tx[0]);
        else passed++;
        total++;
        if (n_st[0] - s0 !== 1 || n_fe[0] - f0 !== 1 || n_abt[0] - a0 !== 0)
            $display("FAIL preload_frame start=%0d end=%0d abort=%0d expected 1/1/0",
                     n_st[0] - s0, n_fe[0] - f0, n_abt[0] - a0);
        else passed++;
        // the trailing edge after the word loads the next one from an empty buffer
        total++;
        if (n_und[0] - u0 !== 1) $display("FAIL preload_underrun got %0d expected 1", n_und[0] - u0);
        else passed++;
    endtask

    task automatic test_fill();
        int v0, u0;
        v0 = n_vrx[0]; u0 = n_und[0];
        m_tx[0] = 16'h0011; m_tx[1] = 16'h0022;
        spi_frame(0, 8, 0, 1'b1, 16, 1'b1);
        total++;
        if (m_rx[0][7:0] !== 8'hFF || m_rx[1][7:0] !== 8'hFF)
            $display("FAIL fill_miso got %h %h expected ff ff", m_rx[0][7:0], m_rx[1][7:0]);
        else passed++;
        total++;
        if (n_vrx[0] - v0 !== 2 || rx_hist[0][v0 % 8] !== 16'h0011 || data_rx_a[0] !== 16'h0022)
            $display("FAIL fill_rx got %0d %h %h expected 2 0011 0022", n_vrx[0] - v0,
                     rx_hist[0][v0 % 8], data_rx_a[0]);
        else passed++;
        // loads: frame start, after word 1, after word 2
        total++;
        if (n_und[0] - u0 !== 3) $display("FAIL fill_underrun got %0d expected 3", n_und[0] - u0);
        else passed++;
    endtask

    task automatic test_abort();
        int v0, a0, f0;
        v0 = n_vrx[0]; a0 = n_abt[0]; f0 = n_fe[0];
        m_tx[0] = 16'h005F;
        spi_frame(0, 8, 0, 1'b1, 5, 1'b1);
        total++;
        if (n_abt[0] - a0 !== 1 || n_fe[0] - f0 !== 1)
            $display("FAIL abort_pulse abort=%0d end=%0d expected 1/1", n_abt[0] - a0, n_fe[0] - f0);
        else passed++;
        total++;
        if (n_vrx[0] - v0 !== 0 || data_rx_a[0] !== 16'h0022)
            $display("FAIL abort_rx got %0d %h expected 0 0022", n_vrx[0] - v0, data_rx_a[0]);
        else passed++;
        a0 = n_abt[0];
        m_tx[0] = 16'h0096;
        spi_frame(0, 8, 0, 1'b1, 8, 1'b1);
        total++;
        if (data_rx_a[0] !== 16'h0096 || n_vrx[0] - v0 !== 1 || n_abt[0] - a0 !== 0)
            $display("FAIL abort_next got %h %0d %0d expected 0096 1 0", data_rx_a[0],
                     n_vrx[0] - v0, n_abt[0] - a0);
        else passed++;
    endtask

    task automatic test_modes();
        logic [15:0] words [3];
        int          cpha, v0, u0;
        words[0] = 16'h1234; words[1] = 16'h5678; words[2] = 16'h9ABC;
        for (int m = 1; m <= 4; m++) begin
            cpha = (m - 1) % 2;
            for (int k = 0; k < 3; k++) begin
                txq[m].push_back(words[k]);
                m_tx[k] = words[k];
            end
            // CPHA=0 loads once more on the final trailing edge
            if (cpha == 0) txq[m].push_back(16'h0000);
            wait_loaded(m);
            v0 = n_vrx[m]; u0 = n_und[m];
            spi_frame(m, 16, cpha, 1'b1, 48, 1'b1);
            for (int k = 0; k < 3; k++) begin
                total++;
                if (m_rx[k] !== words[k])
                    $display("FAIL mode%0d_miso word %0d got %h expected %h", m - 1, k, m_rx[k], words[k]);
                else passed++;
                total++;
                if (rx_hist[m][(v0 + k) % 8] !== words[k])
                    $display("FAIL mode%0d_rx word %0d got %h expected %h", m - 1, k,
                             rx_hist[m][(v0 + k) % 8], words[k]);
                else passed++;
            end
            total++;
            if (n_vrx[m] - v0 !== 3 || n_und[m] - u0 !== 0)
                $display("FAIL mode%0d_counts valid=%0d underrun=%0d expected 3/0", m - 1,
                         n_vrx[m] - v0, n_und[m] - u0);
            else passed++;
        end
    endtask

    task automatic test_lsb_first();
        txq[5].push_back(16'h0001);
        wait_loaded(5);
        m_tx[0] = 16'h0080;
        spi_frame(5, 8, 0, 1'b0, 8, 1'b1);
        total++;
        if (first_bit !== 1'b1) $display("FAIL lsb_first_bit got %b expected 1", first_bit);
        else passed++;
        total++;
        if (m_rx[0][7:0] !== 8'h01 || data_rx_a[5] !== 16'h0080)
            $display("FAIL lsb_word miso=%h rx=%h expected 01 0080", m_rx[0][7:0], data_rx_a[5]);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int v0, a0;
        m_tx[0] = 16'h00FF;
        spi_frame(0, 8, 0, 1'b1, 3, 1'b0);
        rst_n = 1'b0;
        #1;
        total++;
        if (data_rx_a[0] !== 16'h0000 || ready_tx[0] !== 1'b1 || so[0] !== 1'b0)
            $display("FAIL rstmid_state rx=%h ready=%b so=%b expected 0000 1 0", data_rx_a[0],
                     ready_tx[0], so[0]);
        else passed++;
        total++;
        if ({valid_rx[0], start[0], frame_end[0], abort[0], tx_underrun[0]} !== 5'b00000 ||
            so_oe[0] !== 1'b1)
            $display("FAIL rstmid_pulses got %b so_oe=%b expected 00000 1",
                     {valid_rx[0], start[0], frame_end[0], abort[0], tx_underrun[0]}, so_oe[0]);
        else passed++;
        @(negedge clk);
        n_cs[0] = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        txq[0].push_back(16'h005A);
        wait_loaded(0);
        v0 = n_vrx[0]; a0 = n_abt[0];
        m_tx[0] = 16'h00C3;
        spi_frame(0, 8, 0, 1'b1, 8, 1'b1);
        total++;
        if (m_rx[0][7:0] !== 8'h5A || data_rx_a[0] !== 16'h00C3)
            $display("FAIL rstmid_frame miso=%h rx=%h expected 5a 00c3", m_rx[0][7:0], data_rx_a[0]);
        else passed++;
        total++;
        if (n_vrx[0] - v0 !== 1 || n_abt[0] - a0 !== 0)
            $display("FAIL rstmid_counts valid=%0d abort=%0d expected 1/0", n_vrx[0] - v0, n_abt[0] - a0);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_preload();
        test_fill();
        test_abort();
        test_modes();
        test_lsb_first();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish, %0d/%0d so far", passed, total);
        $fatal(1);
    end

endmodule
